// File: rtl/nv_nvdla_csc_pra_cell_chn_data_in_rsci_rx_pkg.sv
// Shared definitions for the pra_cell chn_data_in receive path.
// Holds the width defaults, the FIFO depth and the occupancy encoding.
package nv_nvdla_csc_pra_cell_chn_data_in_rsci_rx_pkg;
   localparam int DATA_W_DEF = 256;
   localparam int CNT_W_DEF  = 16;
   localparam int FIFO_DEPTH = 2;

   typedef enum logic [1:0] {
      CNT_EMPTY = 2'd0,
      CNT_ONE   = 2'd1,
      CNT_FULL  = 2'd2
   } fifo_cnt_e;
endpackage

// File: rtl/nv_nvdla_csc_pra_cell_skid2.sv
// Two-entry FIFO between upstream chn_data_in and the pra_cell core.
// Entry 0 is always the head; it keeps its last value after the FIFO drains.
module nv_nvdla_csc_pra_cell_skid2
   import nv_nvdla_csc_pra_cell_chn_data_in_rsci_rx_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              nvdla_core_clk,
   input  logic              nvdla_core_rstn,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] push_data,
   output logic              not_full,
   output logic              not_empty,
   output logic [DATA_W-1:0] head_data
);

   fifo_cnt_e         count_reg;
   fifo_cnt_e         count_next;
   logic [DATA_W-1:0] entry_reg  [FIFO_DEPTH];
   logic [DATA_W-1:0] entry_next [FIFO_DEPTH];

   always_comb begin
      count_next    = count_reg;
      entry_next[0] = entry_reg[0];
      entry_next[1] = entry_reg[1];
      case (count_reg)
         CNT_EMPTY: begin
            if (push) begin
               entry_next[0] = push_data;
               count_next    = CNT_ONE;
            end
         end
         CNT_ONE: begin
            // Simultaneous push and pop replaces the head in place.
            if (push && pop) begin
               entry_next[0] = push_data;
            end else if (push) begin
               entry_next[1] = push_data;
               count_next    = CNT_FULL;
            end else if (pop) begin
               count_next    = CNT_EMPTY;
            end
         end
         CNT_FULL: begin
            if (pop) begin
               entry_next[0] = entry_reg[1];
               count_next    = CNT_ONE;
            end
         end
         default: count_next = CNT_EMPTY;
      endcase
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         count_reg    <= CNT_EMPTY;
         entry_reg[0] <= '0;
         entry_reg[1] <= '0;
      end else begin
         count_reg    <= count_next;
         entry_reg[0] <= entry_next[0];
         entry_reg[1] <= entry_next[1];
      end
   end

   assign not_full  = (count_reg != CNT_FULL);
   assign not_empty = (count_reg != CNT_EMPTY);
   assign head_data = entry_reg[0];

endmodule

// File: rtl/nv_nvdla_csc_pra_cell_chn_data_in_rsci_rx.sv
// Receive side of the pra_cell chn_data_in handshake: skid FIFO towards the core,
// oswt/bawt/wen_comp signalling and a saturating stall counter for perf debug.
module nv_nvdla_csc_pra_cell_chn_data_in_rsci_rx
   import nv_nvdla_csc_pra_cell_chn_data_in_rsci_rx_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              nvdla_core_clk,
   input  logic              nvdla_core_rstn,
   input  logic              chn_data_in_vld,
   output logic              chn_data_in_rdy,
   input  logic [DATA_W-1:0] chn_data_in_pd,
   input  logic              core_rd_oswt,
   input  logic              core_rd_en,
   output logic              core_rd_bawt,
   output logic              core_rd_wen_comp,
   output logic [DATA_W-1:0] core_rd_data,
   input  logic              stall_cnt_clr,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic             push;
   logic             pop;
   logic             stall;
   logic [CNT_W-1:0] stall_cnt_reg;
   logic [CNT_W-1:0] stall_cnt_next;

   assign push  = chn_data_in_vld & chn_data_in_rdy;
   assign pop   = core_rd_oswt & core_rd_en & core_rd_bawt;
   assign stall = core_rd_oswt & ~core_rd_bawt;

   nv_nvdla_csc_pra_cell_skid2 #(
      .DATA_W (DATA_W)
   ) u_fifo (
      .nvdla_core_clk  (nvdla_core_clk),
      .nvdla_core_rstn (nvdla_core_rstn),
      .push            (push),
      .pop             (pop),
      .push_data       (chn_data_in_pd),
      .not_full        (chn_data_in_rdy),
      .not_empty       (core_rd_bawt),
      .head_data       (core_rd_data)
   );

   // wen_comp deliberately ignores core_rd_en: the core stalls on data, not on its own enable.
   assign core_rd_wen_comp = ~core_rd_oswt | core_rd_bawt;

   always_comb begin
      stall_cnt_next = stall_cnt_reg;
      if (stall_cnt_clr) begin
         stall_cnt_next = '0;
      end else if (stall && !(&stall_cnt_reg)) begin
         stall_cnt_next = stall_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         stall_cnt_reg <= '0;
      end else begin
         stall_cnt_reg <= stall_cnt_next;
      end
   end

   assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_nv_nvdla_csc_pra_cell_chn_data_in_rsci_rx.sv
// Directed bench for the chn_data_in receive path: accepted beats go into a
// scoreboard queue and a negedge monitor checks every core pop against it.
module tb_nv_nvdla_csc_pra_cell_chn_data_in_rsci_rx;
   localparam int DATA_W = 256;
   localparam int CNT_W  = 16;

   logic              nvdla_core_clk;
   logic              nvdla_core_rstn;
   logic              chn_data_in_vld;
   logic              chn_data_in_rdy;
   logic [DATA_W-1:0] chn_data_in_pd;
   logic              core_rd_oswt;
   logic              core_rd_en;
   logic              core_rd_bawt;
   logic              core_rd_wen_comp;
   logic [DATA_W-1:0] core_rd_data;
   logic              stall_cnt_clr;
   logic [CNT_W-1:0]  stall_cnt;

   int checks;
   int failures;
   logic [DATA_W-1:0] exp_q[$];

   nv_nvdla_csc_pra_cell_chn_data_in_rsci_rx #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) dut (
      .nvdla_core_clk   (nvdla_core_clk),
      .nvdla_core_rstn  (nvdla_core_rstn),
      .chn_data_in_vld  (chn_data_in_vld),
      .chn_data_in_rdy  (chn_data_in_rdy),
      .chn_data_in_pd   (chn_data_in_pd),
      .core_rd_oswt     (core_rd_oswt),
      .core_rd_en       (core_rd_en),
      .core_rd_bawt     (core_rd_bawt),
      .core_rd_wen_comp (core_rd_wen_comp),
      .core_rd_data     (core_rd_data),
      .stall_cnt_clr    (stall_cnt_clr),
      .stall_cnt        (stall_cnt)
   );

   initial nvdla_core_clk = 1'b0;
   always #5 nvdla_core_clk = ~nvdla_core_clk;

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end else begin
         $display("ok   %s value=%0h", name, act);
      end
   endtask

   // Monitor: a pop commits at the next posedge whenever oswt & en & bawt.
   always @(negedge nvdla_core_clk) begin
      if (nvdla_core_rstn && core_rd_oswt && core_rd_en && core_rd_bawt) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_unexpected actual=%0h required=<no beat>", core_rd_data);
         end else begin
            chk("pop_data", core_rd_data, exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge nvdla_core_clk);
      #1;
   endtask

   // Drive one beat and wait (bounded) for the handshake.
   task automatic send(input logic [DATA_W-1:0] d);
      bit done;
      done = 1'b0;
      chn_data_in_vld = 1'b1;
      chn_data_in_pd  = d;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge nvdla_core_clk);
         if (chn_data_in_rdy) begin
            exp_q.push_back(d);
            done = 1'b1;
         end
         step();
      end
      chn_data_in_vld = 1'b0;
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=rdy_low required=handshake pd=%0h", d);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      nvdla_core_rstn = 1'b0;
      chn_data_in_vld = 1'b0;
      chn_data_in_pd  = '0;
      core_rd_oswt    = 1'b0;
      core_rd_en      = 1'b0;
      stall_cnt_clr   = 1'b0;
      repeat (3) @(posedge nvdla_core_clk);
      #1;
      @(negedge nvdla_core_clk);
      chk("reset_rdy", DATA_W'(chn_data_in_rdy), 1);
      chk("reset_bawt", DATA_W'(core_rd_bawt), 0);
      chk("reset_data", core_rd_data, 0);
      chk("reset_stall_cnt", DATA_W'(stall_cnt), 0);
      nvdla_core_rstn = 1'b1;
      step();

      // 1: single beat, visible the next cycle
      send(256'hA5);
      @(negedge nvdla_core_clk);
      chk("t1_bawt", DATA_W'(core_rd_bawt), 1);
      chk("t1_data", core_rd_data, 256'hA5);
      chk("t1_rdy", DATA_W'(chn_data_in_rdy), 1);
      chk("t1_wen_comp", DATA_W'(core_rd_wen_comp), 1);
      step();
      core_rd_oswt = 1'b1;
      core_rd_en   = 1'b1;
      step();
      core_rd_oswt = 1'b0;
      core_rd_en   = 1'b0;
      @(negedge nvdla_core_clk);
      chk("t1_drained_bawt", DATA_W'(core_rd_bawt), 0);
      chk("t1_hold_data", core_rd_data, 256'hA5);
      step();

      // 2: fill, back-pressure, en=0 hold, then drain in order
      send(256'h1);
      send(256'h2);
      chn_data_in_vld = 1'b1;
      chn_data_in_pd  = 256'h3;
      core_rd_oswt    = 1'b1;
      core_rd_en      = 1'b0;
      @(negedge nvdla_core_clk);
      chk("t2_full_rdy", DATA_W'(chn_data_in_rdy), 0);
      chk("t2_en0_data", core_rd_data, 256'h1);
      chk("t2_en0_wen_comp", DATA_W'(core_rd_wen_comp), 1);
      step();
      core_rd_en = 1'b1;
      @(negedge nvdla_core_clk);
      chk("t2_still_full", DATA_W'(chn_data_in_rdy), 0);
      step();
      core_rd_oswt = 1'b0;
      core_rd_en   = 1'b0;
      @(negedge nvdla_core_clk);
      chk("t2_rdy_after_pop", DATA_W'(chn_data_in_rdy), 1);
      chk("t2_head_after_pop", core_rd_data, 256'h2);
      if (chn_data_in_rdy) exp_q.push_back(256'h3);
      step();
      chn_data_in_vld = 1'b0;
      core_rd_oswt = 1'b1;
      core_rd_en   = 1'b1;
      step();
      step();
      core_rd_oswt = 1'b0;
      core_rd_en   = 1'b0;
      @(negedge nvdla_core_clk);
      chk("t2_empty", DATA_W'(core_rd_bawt), 0);
      step();

      // 3: steady stream, one beat per cycle at count 1
      core_rd_oswt = 1'b1;
      core_rd_en   = 1'b1;
      chn_data_in_vld = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chn_data_in_pd = DATA_W'(32'h100 + i);
         @(negedge nvdla_core_clk);
         if (i > 0) chk("t3_bawt", DATA_W'(core_rd_bawt), 1);
         chk("t3_rdy", DATA_W'(chn_data_in_rdy), 1);
         if (chn_data_in_rdy) exp_q.push_back(chn_data_in_pd);
         step();
      end
      chn_data_in_vld = 1'b0;
      step();
      core_rd_oswt = 1'b0;
      core_rd_en   = 1'b0;
      @(negedge nvdla_core_clk);
      chk("t3_drained", DATA_W'(core_rd_bawt), 0);
      chk("t3_queue_empty", DATA_W'(exp_q.size()), 0);

      // 4: stall counting and clear priority
      stall_cnt_clr = 1'b1;
      step();
      stall_cnt_clr = 1'b0;
      core_rd_oswt  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge nvdla_core_clk);
         chk("t4_wen_comp", DATA_W'(core_rd_wen_comp), 0);
         step();
      end
      @(negedge nvdla_core_clk);
      chk("t4_stall_cnt", DATA_W'(stall_cnt), 5);
      stall_cnt_clr = 1'b1;
      step();
      stall_cnt_clr = 1'b0;
      core_rd_oswt  = 1'b0;
      @(negedge nvdla_core_clk);
      chk("t4_clr_priority", DATA_W'(stall_cnt), 0);
      step();

      // 5: saturation; counter climbs from 0 to 0xFFFE by real stall cycles
      core_rd_oswt = 1'b1;
      repeat (16'hFFFE) @(posedge nvdla_core_clk);
      #1;
      @(negedge nvdla_core_clk);
      chk("t5_at_fffe", DATA_W'(stall_cnt), 16'hFFFE);
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge nvdla_core_clk);
         chk("t5_saturated", DATA_W'(stall_cnt), 16'hFFFF);
      end
      core_rd_oswt = 1'b0;
      step();

      // 6: asynchronous reset with the FIFO full
      send(256'h11);
      send(256'h22);
      #3;
      nvdla_core_rstn = 1'b0;
      #1;
      chk("t6_rst_bawt", DATA_W'(core_rd_bawt), 0);
      chk("t6_rst_rdy", DATA_W'(chn_data_in_rdy), 1);
      chk("t6_rst_data", core_rd_data, 0);
      chk("t6_rst_stall_cnt", DATA_W'(stall_cnt), 0);
      exp_q.delete();
      @(negedge nvdla_core_clk);
      nvdla_core_rstn = 1'b1;
      core_rd_oswt = 1'b1;
      core_rd_en   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge nvdla_core_clk);
         chk("t6_no_stale_bawt", DATA_W'(core_rd_bawt), 0);
      end
      core_rd_oswt = 1'b0;
      core_rd_en   = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
